merge_rr: RTL and testbench

MERGE_RR -- requirements
Module: merge_rr

---
 rtl/merge_rr.sv | 182 ++++++++++++++++++
 tb/tb_merge_rr.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_rr.sv
// merge_rr: N-to-1 request merger with zero-latency grant and in-order response routing.
// Default arbitration is round-robin; define MERGE_RR_FIXED_PRIO_EN for fixed priority (highest index wins).
module merge_rr #(
    parameter int N_MASTERS   = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_MASTERS-1:0]              m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]       m_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
    output logic [N_MASTERS-1:0]              m_ready,
    output logic [N_MASTERS-1:0]              m_rvalid,
    output logic [N_MASTERS*DATA_W-1:0]       m_rdata,
    output logic                              s_valid,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic [DATA_W-1:0]                 s_wdata,
    output logic [DATA_W/8-1:0]               s_wstrb,
    input  logic                              s_ready,
    input  logic                              s_rvalid,
    input  logic [DATA_W-1:0]                 s_rdata,
    output logic [$clog2(OUTST_DEPTH):0]      outst_cnt,
    output logic                              err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PTR_W  = $clog2(OUTST_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_DEPTH);

    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] tag_mem_q [OUTST_DEPTH];

    logic             full, empty;
    logic             arb_vld, grant_vld, accept, pop;
    logic [IDX_W-1:0] arb_idx, grant_idx, head_idx;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign accept   = grant_vld & s_ready;
    assign pop      = s_rvalid & ~empty;
    assign head_idx = tag_mem_q[rd_ptr_q];

`ifndef MERGE_RR_FIXED_PRIO_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    assign last_grant_d = accept ? grant_idx : last_grant_q;

    // Reset points last_grant at the top master so master 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= LAST_IDX;
        else        last_grant_q <= last_grant_d;
    end
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
`ifdef MERGE_RR_FIXED_PRIO_EN
        for (int k = 0; k < N_MASTERS; k++) begin
            if (m_valid[k]) begin
                arb_vld = 1'b1;
                arb_idx = IDX_W'(k);
            end
        end
`else
        // Walk the distances farthest-first so the nearest valid master after last_grant wins.
        for (int i = N_MASTERS; i >= 1; i--) begin
            for (int k = 0; k < N_MASTERS; k++) begin
                if (m_valid[k] && (k == (int'(last_grant_q) + i) % N_MASTERS)) begin
                    arb_vld = 1'b1;
                    arb_idx = IDX_W'(k);
                end
            end
        end
`endif
    end

    // A stalled grant stays locked; nothing is granted while the tag FIFO is full or in reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = arb_idx;
        if (rst_n && !full) begin
            if (lock_q) begin
                grant_vld = 1'b1;
                grant_idx = lock_idx_q;
            end else begin
                grant_vld = arb_vld;
            end
        end
    end

    assign s_valid = grant_vld;

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_ready = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                s_addr     = m_addr[k*ADDR_W +: ADDR_W];
                s_wdata    = m_wdata[k*DATA_W +: DATA_W];
                s_wstrb    = m_wstrb[k*STRB_W +: STRB_W];
                m_ready[k] = accept;
            end
        end
    end

    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (pop && head_idx == IDX_W'(k)) begin
                m_rvalid[k]                  = 1'b1;
                m_rdata[k*DATA_W +: DATA_W] = s_rdata;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (s_rvalid & empty);
        if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (accept) begin
            lock_d = 1'b0;
        end else if (grant_vld) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the tag storage has no reset; entries are only read after being written, under cnt_q.
    always_ff @(posedge clk) begin
        if (accept) tag_mem_q[wr_ptr_q] <= grant_idx;
    end

    assign outst_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_merge_rr.sv
// Self-checking bench for merge_rr (3 masters, depth 4) with an in-order tag scoreboard.
module tb_merge_rr;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int D  = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N-1:0]      m_ready;
    logic [N-1:0]      m_rvalid;
    logic [N*DW-1:0]   m_rdata;
    logic              s_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_ready;
    logic              s_rvalid;
    logic [DW-1:0]     s_rdata;
    logic [2:0]        outst_cnt;
    logic              err;

    merge_rr #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .OUTST_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .outst_cnt(outst_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: scoreboard of outstanding tags plus arbitration memory.
    int q_tag[$];
    int last_m;
    bit lock_m;
    int lock_g;
    bit err_m;

    // Sampled DUT outputs and matching model expectations for the most recent cycle.
    logic          obs_s_valid, obs_err;
    logic [AW-1:0] obs_s_addr;
    logic [DW-1:0] obs_s_wdata;
    logic [SW-1:0] obs_s_wstrb;
    logic [N-1:0]  obs_m_ready, obs_m_rvalid;
    logic [N*DW-1:0] obs_m_rdata;
    logic [2:0]    obs_cnt;
    logic          exp_s_valid, exp_err;
    logic [AW-1:0] exp_s_addr;
    logic [N-1:0]  exp_m_ready, exp_m_rvalid;
    logic [N*DW-1:0] exp_m_rdata;
    logic [2:0]    exp_cnt;

    function automatic logic [AW-1:0] addr_of(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h100;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int k);
        return 32'hCAFE_0000 | 32'(k);
    endfunction

    function automatic logic [SW-1:0] wstrb_of(input int k);
        return (k == 1) ? 4'h0 : ((k == 0) ? 4'hF : 4'h3);
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        int r = -1;
`ifdef MERGE_RR_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (v[k]) r = k;
`else
        for (int i = 1; i <= N; i++) begin
            int c = (last_m + i) % N;
            if (v[c] && r < 0) r = c;
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        q_tag.delete();
        last_m = N - 1;
        lock_m = 1'b0;
        lock_g = 0;
        err_m  = 1'b0;
    endtask

    // Drive one cycle at the falling edge, sample combinational outputs 1ns later,
    // update the scoreboard, then sample registered outputs at the next falling edge.
    task automatic drive_cycle(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [DW-1:0] rd);
        int g;
        int t;
        m_valid  = v;
        s_ready  = rdy;
        s_rvalid = rv;
        s_rdata  = rd;
        #1;
        obs_s_valid  = s_valid;
        obs_s_addr   = s_addr;
        obs_s_wdata  = s_wdata;
        obs_s_wstrb  = s_wstrb;
        obs_m_ready  = m_ready;
        obs_m_rvalid = m_rvalid;
        obs_m_rdata  = m_rdata;

        g = -1;
        if (q_tag.size() < D) g = lock_m ? lock_g : pick(v);
        exp_s_valid = (g >= 0);
        exp_s_addr  = (g >= 0) ? addr_of(g) : '0;
        exp_m_ready = (g >= 0 && rdy) ? N'(1 << g) : '0;

        exp_m_rvalid = '0;
        exp_m_rdata  = '0;
        if (rv) begin
            if (q_tag.size() > 0) begin
                t = q_tag.pop_front();
                exp_m_rvalid = N'(1 << t);
                exp_m_rdata[t*DW +: DW] = rd;
            end else begin
                err_m = 1'b1;
            end
        end
        if (g >= 0 && rdy) begin
            q_tag.push_back(g);
            last_m = g;
            lock_m = 1'b0;
        end else if (g >= 0) begin
            lock_m = 1'b1;
            lock_g = g;
        end
        exp_cnt = 3'(q_tag.size());
        exp_err = err_m;

        @(negedge clk);
        obs_cnt = outst_cnt;
        obs_err = err;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        m_valid  = '1;
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        m_valid  = '0;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if (s_valid !== 1'b0 || m_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_req: got s_valid=%b m_ready=%b, want 0/000", s_valid, m_ready);
        end
        n_cmp++;
        if (m_rvalid !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_rvalid: got %b, want 000", m_rvalid);
        end
        n_cmp++;
        if (outst_cnt !== 3'd0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got cnt=%0d err=%b, want 0/0", outst_cnt, err);
        end
        release_reset();
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(3'b111, 1'b1, (i > 0), 32'hA000_0000 + 32'(i));
            n_cmp++;
            if (obs_s_valid !== 1'b1 || obs_s_addr !== addr_of(seq[i]) || obs_m_ready !== 3'(1 << seq[i])) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got valid=%b addr=%h ready=%b, want 1 addr=%h ready=%b",
                         i, obs_s_valid, obs_s_addr, obs_m_ready, addr_of(seq[i]), 3'(1 << seq[i]));
            end
            n_cmp++;
            if (obs_s_wdata !== wdata_of(seq[i]) || obs_s_wstrb !== wstrb_of(seq[i])) begin
                n_bad++;
                $display("FAIL rr_fields[%0d]: got wdata=%h wstrb=%h, want %h %h",
                         i, obs_s_wdata, obs_s_wstrb, wdata_of(seq[i]), wstrb_of(seq[i]));
            end
            n_cmp++;
            if (obs_m_rvalid !== exp_m_rvalid || obs_m_rdata !== exp_m_rdata) begin
                n_bad++;
                $display("FAIL rr_resp[%0d]: got rvalid=%b rdata=%h, want %b %h",
                         i, obs_m_rvalid, obs_m_rdata, exp_m_rvalid, exp_m_rdata);
            end
            n_cmp++;
            if (obs_cnt !== 3'd1) begin
                n_bad++;
                $display("FAIL rr_cnt[%0d]: got %0d, want 1", i, obs_cnt);
            end
        end
        drive_cycle(3'b000, 1'b0, 1'b1, 32'hA000_00FF);
        n_cmp++;
        if (obs_m_rvalid !== 3'b100 || obs_m_rdata !== exp_m_rdata || obs_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL rr_drain: got rvalid=%b rdata=%h cnt=%0d, want 100 %h 0",
                     obs_m_rvalid, obs_m_rdata, obs_cnt, exp_m_rdata);
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 3; i++) begin
            drive_cycle((i >= 1) ? 3'b110 : 3'b010, 1'b0, 1'b0, '0);
            n_cmp++;
            if (obs_s_valid !== 1'b1 || obs_s_addr !== addr_of(1) || obs_m_ready !== 3'b000) begin
                n_bad++;
                $display("FAIL lock_hold[%0d]: got valid=%b addr=%h ready=%b, want 1 addr=%h ready=000",
                         i, obs_s_valid, obs_s_addr, obs_m_ready, addr_of(1));
            end
        end
        drive_cycle(3'b110, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_s_addr !== addr_of(1) || obs_m_ready !== 3'b010) begin
            n_bad++;
            $display("FAIL lock_accept1: got addr=%h ready=%b, want %h 010", obs_s_addr, obs_m_ready, addr_of(1));
        end
        drive_cycle(3'b100, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_s_addr !== addr_of(2) || obs_m_ready !== 3'b100 || obs_cnt !== 3'd2) begin
            n_bad++;
            $display("FAIL lock_accept2: got addr=%h ready=%b cnt=%0d, want %h 100 2",
                     obs_s_addr, obs_m_ready, obs_cnt, addr_of(2));
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(3'b000, 1'b0, 1'b1, 32'hB000_0000 + 32'(i));
            n_cmp++;
            if (obs_m_rvalid !== exp_m_rvalid || obs_m_rdata !== exp_m_rdata) begin
                n_bad++;
                $display("FAIL lock_resp[%0d]: got rvalid=%b rdata=%h, want %b %h",
                         i, obs_m_rvalid, obs_m_rdata, exp_m_rvalid, exp_m_rdata);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < D; i++) begin
            drive_cycle(3'b111, 1'b1, 1'b0, '0);
            n_cmp++;
            if (obs_s_valid !== exp_s_valid || obs_s_addr !== exp_s_addr || obs_m_ready !== exp_m_ready) begin
                n_bad++;
                $display("FAIL full_fill[%0d]: got valid=%b addr=%h ready=%b, want %b %h %b",
                         i, obs_s_valid, obs_s_addr, obs_m_ready, exp_s_valid, exp_s_addr, exp_m_ready);
            end
        end
        drive_cycle(3'b111, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_s_valid !== 1'b0 || obs_m_ready !== 3'b000 || obs_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL full_block: got valid=%b ready=%b cnt=%0d, want 0 000 4", obs_s_valid, obs_m_ready, obs_cnt);
        end
        drive_cycle(3'b111, 1'b1, 1'b1, 32'hC000_0005);
        n_cmp++;
        if (obs_s_valid !== 1'b0 || obs_m_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL full_pop_no_grant: got valid=%b ready=%b, want 0 000", obs_s_valid, obs_m_ready);
        end
        n_cmp++;
        if (obs_m_rvalid !== exp_m_rvalid || obs_m_rdata !== exp_m_rdata || obs_cnt !== 3'd3) begin
            n_bad++;
            $display("FAIL full_pop: got rvalid=%b rdata=%h cnt=%0d, want %b %h 3",
                     obs_m_rvalid, obs_m_rdata, obs_cnt, exp_m_rvalid, exp_m_rdata);
        end
        drive_cycle(3'b111, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_s_valid !== 1'b1 || obs_s_addr !== exp_s_addr || obs_cnt !== 3'd4) begin
            n_bad++;
            $display("FAIL full_resume: got valid=%b addr=%h cnt=%0d, want 1 %h 4", obs_s_valid, obs_s_addr, obs_cnt, exp_s_addr);
        end
        for (int i = 0; i < D; i++) begin
            drive_cycle(3'b000, 1'b0, 1'b1, 32'hC100_0000 + 32'(i));
            n_cmp++;
            if (obs_m_rvalid !== exp_m_rvalid || obs_m_rdata !== exp_m_rdata || obs_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL full_drain[%0d]: got rvalid=%b rdata=%h cnt=%0d, want %b %h %0d",
                         i, obs_m_rvalid, obs_m_rdata, obs_cnt, exp_m_rvalid, exp_m_rdata, exp_cnt);
            end
        end
    endtask

    task automatic test_order();
        logic [N-1:0] order_v[3]  = '{3'b100, 3'b001, 3'b010};
        logic [DW-1:0] resp_d[3]  = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(order_v[i], 1'b1, 1'b0, '0);
            n_cmp++;
            if (obs_m_ready !== order_v[i]) begin
                n_bad++;
                $display("FAIL order_accept[%0d]: got ready=%b, want %b", i, obs_m_ready, order_v[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(3'b000, 1'b0, 1'b1, resp_d[i]);
            n_cmp++;
            if (obs_m_rvalid !== order_v[i] || obs_m_rdata !== exp_m_rdata) begin
                n_bad++;
                $display("FAIL order_resp[%0d]: got rvalid=%b rdata=%h, want %b %h",
                         i, obs_m_rvalid, obs_m_rdata, order_v[i], exp_m_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(3'b001, 1'b1, 1'b0, '0);
        drive_cycle(3'b010, 1'b1, 1'b1, 32'hD000_0001);
        n_cmp++;
        if (obs_m_ready !== 3'b010 || obs_m_rvalid !== 3'b001 || obs_m_rdata !== exp_m_rdata) begin
            n_bad++;
            $display("FAIL b2b_push_pop: got ready=%b rvalid=%b rdata=%h, want 010 001 %h",
                     obs_m_ready, obs_m_rvalid, obs_m_rdata, exp_m_rdata);
        end
        n_cmp++;
        if (obs_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL b2b_cnt: got %0d, want 1", obs_cnt);
        end
        drive_cycle(3'b000, 1'b0, 1'b1, 32'hD000_0002);
        n_cmp++;
        if (obs_m_rvalid !== 3'b010 || obs_m_rdata !== exp_m_rdata || obs_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL b2b_drain: got rvalid=%b rdata=%h cnt=%0d, want 010 %h 0",
                     obs_m_rvalid, obs_m_rdata, obs_cnt, exp_m_rdata);
        end
    endtask

    task automatic test_err();
        drive_cycle(3'b000, 1'b0, 1'b1, 32'h5555_5555);
        n_cmp++;
        if (obs_m_rvalid !== 3'b000 || obs_m_rdata !== '0 || obs_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got rvalid=%b rdata=%h err=%b, want 000 0 1", obs_m_rvalid, obs_m_rdata, obs_err);
        end
        drive_cycle(3'b000, 1'b0, 1'b0, '0);
        n_cmp++;
        if (obs_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b, want 1", obs_err);
        end
        drive_cycle(3'b001, 1'b1, 1'b1, 32'h6666_6666);
        n_cmp++;
        if (obs_m_ready !== 3'b001 || obs_m_rvalid !== 3'b000 || obs_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL err_empty_same_cycle: got ready=%b rvalid=%b cnt=%0d, want 001 000 1",
                     obs_m_ready, obs_m_rvalid, obs_cnt);
        end
        drive_cycle(3'b010, 1'b1, 1'b0, '0);
        apply_reset();
        #1;
        n_cmp++;
        if (outst_cnt !== 3'd0 || err !== 1'b0 || s_valid !== 1'b0 || m_ready !== 3'b000 || m_rvalid !== 3'b000) begin
            n_bad++;
            $display("FAIL err_midreset: got cnt=%0d err=%b s_valid=%b ready=%b rvalid=%b, want 0 0 0 000 000",
                     outst_cnt, err, s_valid, m_ready, m_rvalid);
        end
        release_reset();
        drive_cycle(3'b000, 1'b0, 1'b1, 32'h8888_8888);
        n_cmp++;
        if (obs_m_rvalid !== 3'b000 || obs_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_stale_resp: got rvalid=%b err=%b, want 000 1", obs_m_rvalid, obs_err);
        end
        drive_cycle(3'b111, 1'b1, 1'b0, '0);
        n_cmp++;
        if (obs_s_addr !== exp_s_addr || obs_m_ready !== exp_m_ready) begin
            n_bad++;
            $display("FAIL err_first_grant: got addr=%h ready=%b, want %h %b", obs_s_addr, obs_m_ready, exp_s_addr, exp_m_ready);
        end
        apply_reset();
        release_reset();
        n_cmp++;
        if (err !== 1'b0 || outst_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b cnt=%0d, want 0 0", err, outst_cnt);
        end
    endtask

    task automatic test_fixed_prio();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(3'b101, 1'b1, (i > 0), 32'hF000_0000 + 32'(i));
            n_cmp++;
            if (obs_s_valid !== 1'b1 || obs_s_addr !== addr_of(2) || obs_m_ready !== 3'b100) begin
                n_bad++;
                $display("FAIL fixed_grant[%0d]: got valid=%b addr=%h ready=%b, want 1 %h 100",
                         i, obs_s_valid, obs_s_addr, obs_m_ready, addr_of(2));
            end
            n_cmp++;
            if (obs_m_rvalid !== exp_m_rvalid || obs_m_rdata !== exp_m_rdata) begin
                n_bad++;
                $display("FAIL fixed_resp[%0d]: got rvalid=%b rdata=%h, want %b %h",
                         i, obs_m_rvalid, obs_m_rdata, exp_m_rvalid, exp_m_rdata);
            end
        end
        drive_cycle(3'b000, 1'b0, 1'b1, 32'hF000_00FF);
        n_cmp++;
        if (obs_m_rvalid !== 3'b100 || obs_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL fixed_drain: got rvalid=%b cnt=%0d, want 100 0", obs_m_rvalid, obs_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        m_valid  = '0;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW]  = addr_of(k);
            m_wdata[k*DW +: DW] = wdata_of(k);
            m_wstrb[k*SW +: SW] = wstrb_of(k);
        end
        model_reset();
        @(negedge clk);

        test_reset();
`ifdef MERGE_RR_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_lock();
        test_full();
        test_order();
        test_back_to_back();
        test_err();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
